// File: rtl/candy_avb_i2c_master.sv
// Avalon-MM I2C master: START / byte WRITE or READ with ACK / STOP, quarter-bit sequencing.
// Latency: busy rises one clk after CMD write; each phase is 4 quarters of DIV+1 clk (plus any SCL stretch).
// Backpressure: register writes are dropped while busy; a slave holding SCL low pauses the quarter counter.
module candy_avb_i2c_master #(
   parameter logic [15:0] DEFAULT_DIV = 16'd124
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        scl_oe,
   output logic        sda_oe
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_BIT   = 3'd2,
      S_ACK   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [4:0]  cmd_q, cmd_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [15:0] div_q, div_d;
   logic        busy_q, busy_d;
   logic        rx_ack_q, rx_ack_d;
   logic        scl_oe_q, scl_oe_d;
   logic        sda_oe_q, sda_oe_d;

   logic        wr_en;
   logic        cmd_go;
   logic        stretch;
   logic        tick;
   logic        unused_wd;

   // Upper write-data bits carry no register field.
   assign unused_wd = ^writedata[31:16];

   // Next-state: register writes, quarter timing, phase sequencing and the line drive for the next cycle.
   always_comb begin
      state_d  = state_q;
      qtr_d    = qtr_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      cmd_d    = cmd_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      div_d    = div_q;
      busy_d   = busy_q;
      rx_ack_d = rx_ack_q;
      scl_oe_d = scl_oe_q;
      sda_oe_d = sda_oe_q;

      wr_en   = chipselect & ~write_n;
      cmd_go  = wr_en && (address == 2'd1) && !busy_q && (|writedata[3:0]);
      // A slave holding SCL low while we have released it freezes the quarter.
      stretch = ((state_q == S_BIT) || (state_q == S_ACK) || (state_q == S_STOP))
                && (qtr_q == 2'd2) && !scl_in;
      tick    = (state_q != S_IDLE) && !stretch && (cnt_q == div_q);

      if ((state_q == S_IDLE) || stretch || tick) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end

      if (wr_en && !busy_q) begin
         if (address == 2'd0) tx_d  = writedata[7:0];
         if (address == 2'd3) div_d = writedata[15:0];
      end

      if (tick) begin
         qtr_d = qtr_q + 2'd1;
         // Sample SDA at the end of the SCL-high quarter.
         if (qtr_q == 2'd2) begin
            if ((state_q == S_BIT) && !cmd_q[1]) rx_d = {rx_q[6:0], sda_in};
            if ((state_q == S_ACK) && cmd_q[1])  rx_ack_d = sda_in;
         end
         if (qtr_q == 2'd3) begin
            case (state_q)
               S_START: begin
                  if (cmd_q[1] || cmd_q[2]) state_d = S_BIT;
                  else if (cmd_q[3])        state_d = S_STOP;
                  else                      state_d = S_IDLE;
               end
               S_BIT: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = S_ACK;
               end
               S_ACK:   state_d = cmd_q[3] ? S_STOP : S_IDLE;
               S_STOP:  state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
            if (state_d == S_IDLE) busy_d = 1'b0;
         end
      end

      if (cmd_go) begin
         cmd_d  = writedata[4:0];
         busy_d = 1'b1;
         qtr_d  = 2'd0;
         bit_d  = 3'd0;
         if (writedata[0])                      state_d = S_START;
         else if (writedata[1] || writedata[2]) state_d = S_BIT;
         else                                   state_d = S_STOP;
      end

      // Line drive follows the state we are entering so outputs stay registered yet aligned.
      case (state_d)
         S_IDLE: begin
            // After a byte without STOP, park with SCL held low and SDA untouched.
            if (state_q == S_ACK) scl_oe_d = 1'b1;
         end
         S_START: begin
            scl_oe_d = (qtr_d == 2'd3);
            sda_oe_d = qtr_d[1];
         end
         S_BIT: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = cmd_d[1] ? ~tx_q[~bit_d] : 1'b0;
         end
         S_ACK: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = cmd_d[1] ? 1'b0 : ~cmd_d[4];
         end
         S_STOP: begin
            scl_oe_d = (qtr_d == 2'd0);
            sda_oe_d = ~qtr_d[1];
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // All state, including the open-drain enables, registered with asynchronous abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         qtr_q    <= 2'd0;
         cnt_q    <= 16'd0;
         bit_q    <= 3'd0;
         cmd_q    <= 5'd0;
         tx_q     <= 8'd0;
         rx_q     <= 8'd0;
         div_q    <= DEFAULT_DIV;
         busy_q   <= 1'b0;
         rx_ack_q <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         qtr_q    <= qtr_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         cmd_q    <= cmd_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         div_q    <= div_d;
         busy_q   <= busy_d;
         rx_ack_q <= rx_ack_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
      end
   end

   assign scl_oe = scl_oe_q;
   assign sda_oe = sda_oe_q;

   // Zero-wait-state read mux.
   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata = {24'd0, rx_q};
         2'd2:    readdata = {30'd0, rx_ack_q, busy_q};
         2'd3:    readdata = {16'd0, div_q};
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_candy_avb_i2c_master.sv
// Bench for candy_avb_i2c_master: register vectors from a table, then bus transfers checked
// against expected SDA-at-SCL-rise values and rise spacing queued when each command is issued.
// A simple open-drain slave model supplies ACKs, read data and one clock stretch.
module tb_candy_avb_i2c_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        scl_in;
   logic        sda_in;
   logic        scl_oe;
   logic        sda_oe;

   always #5 clk = ~clk;

   candy_avb_i2c_master #(.DEFAULT_DIV(16'd124)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .scl_oe     (scl_oe),
      .sda_oe     (sda_oe)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- bus monitor and slave model ----------------
   int   cyc = 0;
   int   falls = 0;
   int   f_base = 0;
   int   rel;
   int   stretch_cnt = 0;
   logic stretch_req = 1'b0;
   logic stretch_used = 1'b0;
   logic scl_prev = 1'b0;
   logic obs_sda [512];
   int   obs_cyc [512];
   int   obs_wr = 0;
   int   obs_rd = 0;
   logic ack_en = 1'b0;
   logic rd_mode = 1'b0;
   logic [7:0] rd_byte = 8'h00;
   logic pull;
   logic [2:0] idx;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (scl_prev && !scl_oe) begin
         obs_sda[obs_wr % 512] <= sda_oe;
         obs_cyc[obs_wr % 512] <= cyc;
         obs_wr <= obs_wr + 1;
      end
      if (scl_prev && !scl_oe && stretch_req && !stretch_used) begin
         stretch_cnt  <= 20;
         stretch_used <= 1'b1;
      end else if (stretch_cnt > 0) begin
         stretch_cnt <= stretch_cnt - 1;
      end
      if (!scl_prev && scl_oe) falls <= falls + 1;
      scl_prev <= scl_oe;
   end

   assign rel    = falls - f_base;
   assign scl_in = ~scl_oe & (stretch_cnt == 0);

   always_comb begin
      pull = 1'b0;
      idx  = 3'(8 - rel);
      if (ack_en && rel == 9) pull = 1'b1;
      if (rd_mode && rel >= 1 && rel <= 8) pull = ~rd_byte[idx];
   end

   assign sda_in = ~sda_oe & ~pull;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic sda;
      int   iv;
   } rise_t;
   rise_t exp_q[$];

   task automatic push_rise(input logic sda, input int iv);
      rise_t r;
      r.sda = sda;
      r.iv  = iv;
      exp_q.push_back(r);
   endtask

   task automatic push_byte(input logic [7:0] b, input int per);
      for (int i = 0; i < 8; i++) push_rise(~b[7-i], (i == 0) ? 0 : per);
   endtask

   task automatic drain(input string name, input bit partial, input int lim);
      rise_t e;
      int    prev = 0;
      if (!partial) check({name, "_rises"}, 32'(lim - obs_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_rd < lim) begin
         e = exp_q.pop_front();
         check({name, "_sda"}, 32'(obs_sda[obs_rd % 512]), 32'(e.sda));
         if (e.iv != 0) check({name, "_spacing"}, 32'(obs_cyc[obs_rd % 512] - prev), 32'(e.iv));
         prev = obs_cyc[obs_rd % 512];
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   // ---------------- Avalon helpers ----------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      write_n    = 1'b1;
      chipselect = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1 d = readdata;
   endtask

   task automatic wait_idle(input string name, input int budget);
      logic [31:0] s;
      bit done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         bus_read(2'd2, s);
         done = !s[0];
      end
      check({name, "_idle"}, 32'(done), 32'd1);
   endtask

   typedef struct {
      bit          wr;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [1:0]  ra;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vt [9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int snap;

      vt[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0,    "rst_data"};
      vt[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0,    "rst_cmd"};
      vt[2] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0,    "rst_status"};
      vt[3] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'd124,  "rst_div"};
      vt[4] = '{1'b1, 2'd3, 32'hFFFF_1234, 2'd3, 32'h1234, "div_rw"};
      vt[5] = '{1'b1, 2'd1, 32'h0000_0010, 2'd2, 32'h0,    "cmd_nack_only"};
      vt[6] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0,    "status_ro"};
      vt[7] = '{1'b1, 2'd0, 32'h0000_00A5, 2'd0, 32'h0,    "data_rx_only"};
      vt[8] = '{1'b1, 2'd3, 32'h0000_0001, 2'd3, 32'h1,    "div_one"};

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_scl_oe", 32'(scl_oe), 32'd0);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         if (vt[i].wr) bus_write(vt[i].wa, vt[i].wd);
         bus_read(vt[i].ra, rd);
         check(vt[i].name, rd, vt[i].exp);
      end

      // Write 0xA5 with START+STOP, slave ACKs; DIV=1 so a bit is 8 clk.
      bus_write(2'd0, 32'hA5);
      ack_en  = 1'b1;
      rd_mode = 1'b0;
      f_base  = falls;
      push_byte(8'hA5, 8);
      push_rise(1'b0, 8);
      push_rise(1'b1, 6);
      bus_write(2'd1, 32'h0B);
      bus_read(2'd2, rd);
      check("busy_set", rd, 32'h1);
      wait_idle("wr_a5", 500);
      drain("wr_a5", 1'b0, obs_wr);
      bus_read(2'd2, rd);
      check("wr_a5_status", rd, 32'h0);
      check("wr_a5_scl_oe", 32'(scl_oe), 32'd0);
      check("wr_a5_sda_oe", 32'(sda_oe), 32'd0);

      // No device: NACK seen, no STOP, bus parked with SCL low.
      ack_en = 1'b0;
      f_base = falls;
      push_byte(8'hA5, 8);
      push_rise(1'b0, 8);
      bus_write(2'd1, 32'h07);
      wait_idle("nodev", 500);
      drain("nodev", 1'b0, obs_wr);
      bus_read(2'd2, rd);
      check("nodev_status", rd, 32'h2);
      check("nodev_scl_park", 32'(scl_oe), 32'd1);

      // STOP on its own from the parked state.
      push_rise(1'b1, 0);
      bus_write(2'd1, 32'h08);
      wait_idle("stop_only", 200);
      drain("stop_only", 1'b0, obs_wr);
      check("stop_scl_oe", 32'(scl_oe), 32'd0);
      check("stop_sda_oe", 32'(sda_oe), 32'd0);
      bus_read(2'd2, rd);
      check("stop_status", rd, 32'h2);

      // Clock stretch of 20 clk at the first bit's SCL-high quarter, DIV=3.
      bus_write(2'd3, 32'h3);
      bus_write(2'd0, 32'h5A);
      ack_en      = 1'b1;
      stretch_req = 1'b1;
      f_base      = falls;
      push_byte(8'h5A, 16);
      exp_q[1].iv = 16 + 20;
      push_rise(1'b0, 16);
      push_rise(1'b1, 12);
      bus_write(2'd1, 32'h0B);
      wait_idle("stretch", 1000);
      drain("stretch", 1'b0, obs_wr);
      bus_read(2'd2, rd);
      check("stretch_status", rd, 32'h0);

      // READ with NACK, no START/STOP; slave returns 0x3C.
      bus_write(2'd3, 32'h1);
      ack_en  = 1'b0;
      rd_mode = 1'b1;
      rd_byte = 8'h3C;
      f_base  = falls;
      push_byte(8'hFF, 8);
      push_rise(1'b0, 8);
      bus_write(2'd1, 32'h14);
      wait_idle("rd_3c", 500);
      drain("rd_3c", 1'b0, obs_wr);
      rd_mode = 1'b0;
      bus_read(2'd0, rd);
      check("rd_3c_data", rd, 32'h3C);
      bus_read(2'd2, rd);
      check("rd_3c_status", rd, 32'h0);
      repeat (10) @(negedge clk);
      #1;
      check("rd_3c_scl_hold", 32'(scl_oe), 32'd1);
      check("rd_3c_sda_oe", 32'(sda_oe), 32'd0);

      // Writes while busy are dropped; then reset aborts mid-byte.
      ack_en = 1'b1;
      f_base = falls;
      push_rise(1'b0, 0);
      push_byte(8'h5A, 8);
      bus_write(2'd1, 32'h0B);
      bus_write(2'd0, 32'hFF);
      bus_write(2'd3, 32'h0);
      bus_read(2'd3, rd);
      check("busy_div_kept", rd, 32'h1);
      bus_read(2'd0, rd);
      check("busy_data_kept", rd, 32'h3C);
      bus_read(2'd2, rd);
      check("busy_still", rd, 32'h1);
      repeat (34) @(negedge clk);
      #1 snap = obs_wr;
      check("abort_rises_seen", 32'(snap - obs_rd >= 4), 32'd1);
      reset_n = 1'b0;
      #1;
      check("abort_scl_oe", 32'(scl_oe), 32'd0);
      check("abort_sda_oe", 32'(sda_oe), 32'd0);
      address = 2'd2;
      #1 check("abort_status", readdata, 32'h0);
      address = 2'd3;
      #1 check("abort_div", readdata, 32'd124);
      drain("abort", 1'b1, snap);
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(2'd2, rd);
      check("abort_idle", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
